// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer that allocates rename tags, tracks CDB completions,
// answers operand queries and flushes itself after a committed branch mispredict.
module rob_commit #(
    parameter int DEPTH = 32,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic          issue_has_rd,
    input  logic [4:0]    issue_rd,
    input  logic          issue_is_branch,
    output logic [AW-1:0] issue_tag,
    output logic          dependency_set_en,
    output logic [4:0]    dependency_reg,
    output logic [AW-1:0] dependency_dependency,
    input  logic          cdb_valid,
    input  logic [AW-1:0] cdb_tag,
    input  logic [31:0]   cdb_val,
    input  logic          cdb_mispredict,
    input  logic [31:0]   cdb_target,
    input  logic [AW-1:0] query1_tag,
    input  logic [AW-1:0] query2_tag,
    output logic          query1_ready,
    output logic          query2_ready,
    output logic [31:0]   query1_val,
    output logic [31:0]   query2_val,
    output logic          write_en,
    output logic [4:0]    write_id,
    output logic [31:0]   write_val,
    output logic [AW-1:0] write_dependency,
    output logic          dependency_rst,
    output logic          flush_valid,
    output logic [31:0]   flush_pc,
    output logic [AW:0]   count
);
    logic [DEPTH-1:0] busy, rdy, mp, has_rd, is_br;
    logic [4:0]       rd_q [DEPTH];
    logic [31:0]      val_q [DEPTH];
    logic [AW-1:0]    head, tail;
    logic             flush_pending;
    logic [31:0]      flush_pc_buf;
    logic             transfer, commit, cdb_hit, cdb_mp, hit1, hit2;

    // DEPTH is a power of two, so the count MSB alone marks "full"
    assign issue_ready           = !count[AW] && !flush_pending;
    assign issue_tag             = tail;
    assign transfer              = issue_valid && issue_ready;
    assign dependency_set_en     = transfer && issue_has_rd && issue_rd != 5'd0;
    assign dependency_reg        = issue_rd;
    assign dependency_dependency = tail;
    assign commit  = count != '0 && busy[head] && rdy[head] && !flush_pending;
    assign cdb_hit = cdb_valid && busy[cdb_tag] && !flush_pending;
    assign cdb_mp  = cdb_mispredict && is_br[cdb_tag];

    assign hit1         = cdb_valid && cdb_tag == query1_tag;
    assign hit2         = cdb_valid && cdb_tag == query2_tag;
    assign query1_ready = busy[query1_tag] && (rdy[query1_tag] || hit1);
    assign query2_ready = busy[query2_tag] && (rdy[query2_tag] || hit2);
    assign query1_val   = !busy[query1_tag] ? '0 : hit1 ? cdb_val : val_q[query1_tag];
    assign query2_val   = !busy[query2_tag] ? '0 : hit2 ? cdb_val : val_q[query2_tag];

    always_ff @(posedge clk) begin
        if (transfer) begin
            has_rd[tail] <= issue_has_rd;
            is_br[tail]  <= issue_is_branch;
            rd_q[tail]   <= issue_rd;
        end
        if (cdb_hit)
            val_q[cdb_tag] <= cdb_val;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy             <= '0;
            rdy              <= '0;
            mp               <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            flush_pending    <= 1'b0;
            flush_pc_buf     <= '0;
            write_en         <= 1'b0;
            write_id         <= '0;
            write_val        <= '0;
            write_dependency <= '0;
            dependency_rst   <= 1'b0;
            flush_valid      <= 1'b0;
            flush_pc         <= '0;
        end else if (flush_pending) begin
            busy           <= '0;
            rdy            <= '0;
            mp             <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            flush_pending  <= 1'b0;
            write_en       <= 1'b0;
            dependency_rst <= 1'b0;
            flush_valid    <= 1'b0;
        end else begin
            if (cdb_hit) begin
                rdy[cdb_tag] <= 1'b1;
                mp[cdb_tag]  <= cdb_mp;
                if (cdb_mp)
                    flush_pc_buf <= cdb_target;
            end
            if (transfer) begin
                busy[tail] <= 1'b1;
                rdy[tail]  <= 1'b0;
                mp[tail]   <= 1'b0;
                tail       <= tail + 1'b1;
            end
            if (commit) begin
                busy[head]       <= 1'b0;
                head             <= head + 1'b1;
                write_id         <= rd_q[head];
                write_val        <= val_q[head];
                write_dependency <= head;
                if (mp[head])
                    flush_pc <= flush_pc_buf;
            end
            write_en       <= commit && has_rd[head] && rd_q[head] != 5'd0;
            flush_pending  <= commit && mp[head];
            dependency_rst <= commit && mp[head];
            flush_valid    <= commit && mp[head];
            count          <= count + {{AW{1'b0}}, transfer} - {{AW{1'b0}}, commit};
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: randomized scoreboard bench; a program-order queue model predicts commits,
// flushes and query results, and a monitor checks each registered write/flush as it appears.
module tb_rob_commit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        issue_valid = 0, issue_has_rd = 0, issue_is_branch = 0;
    logic [4:0]  issue_rd = 0;
    logic        issue_ready, dependency_set_en, query1_ready, query2_ready;
    logic [4:0]  issue_tag, dependency_reg, dependency_dependency, write_id, write_dependency;
    logic        cdb_valid = 0, cdb_mispredict = 0;
    logic [4:0]  cdb_tag = 0, query1_tag = 0, query2_tag = 0;
    logic [31:0] cdb_val = 0, cdb_target = 0, query1_val, query2_val, write_val, flush_pc;
    logic        write_en, dependency_rst, flush_valid;
    logic [5:0]  count;

    rob_commit dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_has_rd(issue_has_rd),
        .issue_rd(issue_rd), .issue_is_branch(issue_is_branch), .issue_tag(issue_tag),
        .dependency_set_en(dependency_set_en), .dependency_reg(dependency_reg),
        .dependency_dependency(dependency_dependency),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
        .query1_tag(query1_tag), .query2_tag(query2_tag),
        .query1_ready(query1_ready), .query2_ready(query2_ready),
        .query1_val(query1_val), .query2_val(query2_val),
        .write_en(write_en), .write_id(write_id), .write_val(write_val),
        .write_dependency(write_dependency), .dependency_rst(dependency_rst),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  tag;
        bit          hr;
        logic [4:0]  rd;
        bit          br;
        bit          done;
        logic [31:0] val;
        bit          mp;
    } ent_t;

    ent_t        rob[$];
    logic [41:0] exp_w[$];
    logic [31:0] exp_f[$];
    logic [4:0]  m_tail = 0;
    logic [31:0] m_fpc = 0;
    bit          fpend = 0;
    bit          run = 0;
    int          tests = 0, failed = 0;

    task automatic chk(input string nm, input logic [41:0] act, input logic [41:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic qchk(input string nm, input logic [4:0] t, input logic r, input logic [31:0] v);
        bit found = 0, done = 0, hit;
        logic [31:0] sv = 0;
        foreach (rob[i])
            if (rob[i].tag == t) begin
                found = 1;
                done = rob[i].done;
                sv = rob[i].val;
            end
        hit = cdb_valid && cdb_tag == t;
        chk({nm, "_ready"}, r, found && (done || hit));
        if (!found)
            chk({nm, "_val"}, v, 0);
        else if (done || hit)
            chk({nm, "_val"}, v, hit ? cdb_val : sv);
    endtask

    // called at a negedge; drives one cycle, checks combinational outputs, advances the model
    task automatic step(input bit iv, input bit hr, input logic [4:0] rd, input bit br,
                        input bit cv, input logic [4:0] ct, input logic [31:0] cval,
                        input bit cm, input logic [31:0] tgt, input logic [4:0] q1);
        bit exp_rdy, com;
        ent_t c, e;
        logic [31:0] fsnap;
        issue_valid = iv; issue_has_rd = hr; issue_rd = rd; issue_is_branch = br;
        cdb_valid = cv; cdb_tag = ct; cdb_val = cval; cdb_mispredict = cm; cdb_target = tgt;
        query1_tag = q1;
        query2_tag = rob.size() > 0 ? rob[$urandom_range(0, rob.size() - 1)].tag : 5'($urandom);
        #1;
        exp_rdy = rob.size() < 32 && !fpend;
        chk("issue_ready", issue_ready, exp_rdy);
        chk("issue_tag", issue_tag, m_tail);
        chk("count", count, 42'(rob.size()));
        chk("dep_set_en", dependency_set_en, iv && exp_rdy && hr && rd != 0);
        if (iv && exp_rdy) begin
            chk("dep_reg", dependency_reg, rd);
            chk("dep_tag", dependency_dependency, m_tail);
        end
        qchk("q1", query1_tag, query1_ready, query1_val);
        qchk("q2", query2_tag, query2_ready, query2_val);
        if (fpend) begin
            rob.delete();
            m_tail = 0;
            fpend = 0;
        end else begin
            com = rob.size() > 0 && rob[0].done;
            if (com) c = rob[0];
            fsnap = m_fpc;
            if (cv)
                foreach (rob[i])
                    if (rob[i].tag == ct) begin
                        rob[i].done = 1;
                        rob[i].val = cval;
                        rob[i].mp = cm && rob[i].br;
                        if (rob[i].mp) m_fpc = tgt;
                    end
            if (iv && exp_rdy) begin
                e.tag = m_tail; e.hr = hr; e.rd = rd; e.br = br; e.done = 0; e.val = 0; e.mp = 0;
                rob.push_back(e);
                m_tail++;
            end
            if (com) begin
                void'(rob.pop_front());
                if (c.hr && c.rd != 0) exp_w.push_back({c.rd, c.val, c.tag});
                if (c.mp) begin
                    fpend = 1;
                    exp_f.push_back(fsnap);
                end
            end
        end
        @(negedge clk);
    endtask

    // picks a CDB target that is either an incomplete entry or a free tag
    task automatic rstep(input int pi, input int pc);
        logic [4:0] nd[$];
        bit cv = 0;
        logic [4:0] ct = 0;
        foreach (rob[i]) if (!rob[i].done) nd.push_back(rob[i].tag);
        if ($urandom_range(0, 99) < pc) begin
            if (nd.size() > 0 && $urandom_range(0, 3) != 0) begin
                cv = 1;
                ct = nd[$urandom_range(0, nd.size() - 1)];
            end else if (rob.size() < 32) begin
                cv = 1;
                ct = m_tail + 5'($urandom_range(0, 31 - rob.size()));
            end
        end
        step($urandom_range(0, 99) < pi, 1'($urandom), 5'($urandom), $urandom_range(0, 3) == 0,
             cv, ct, $urandom, $urandom_range(0, 9) == 0, $urandom, 5'($urandom));
    endtask

    task automatic drain();
        bit cv;
        logic [4:0] ct;
        for (int n = 0; n < 300 && (rob.size() > 0 || fpend); n++) begin
            cv = 0; ct = 0;
            foreach (rob[i])
                if (!rob[i].done && !cv) begin
                    cv = 1;
                    ct = rob[i].tag;
                end
            step(0, 0, 0, 0, cv, ct, $urandom, 0, 0, 5'($urandom));
        end
        chk("drain_empty", 42'(rob.size()), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        logic [41:0] e;
        if (run) begin
            if (write_en) begin
                if (exp_w.size() == 0) chk("write_unexpected", 1, 0);
                else begin
                    e = exp_w.pop_front();
                    chk("write_id", write_id, e[41:37]);
                    chk("write_val", write_val, e[36:5]);
                    chk("write_dep", write_dependency, e[4:0]);
                end
            end else if (exp_w.size() != 0) begin
                chk("write_missing", 0, 1);
                void'(exp_w.pop_front());
            end
            if (flush_valid || dependency_rst) begin
                chk("dep_rst", dependency_rst, 1);
                chk("flush_valid", flush_valid, 1);
                if (exp_f.size() == 0) chk("flush_unexpected", 1, 0);
                else chk("flush_pc", flush_pc, exp_f.pop_front());
            end else if (exp_f.size() != 0) begin
                chk("flush_missing", 0, 1);
                void'(exp_f.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] t;
        #3;
        chk("rst_write_en", write_en, 0);
        chk("rst_count", count, 0);
        chk("rst_dep_rst", dependency_rst, 0);
        chk("rst_flush_valid", flush_valid, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_write_id", write_id, 0);
        chk("rst_write_val", write_val, 0);
        chk("rst_write_dep", write_dependency, 0);
        chk("rst_issue_ready", issue_ready, 1);
        @(negedge clk);
        rst = 1;
        run = 1;
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        t = m_tail;
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, t);
        step(1, 1, 2, 0, 0, 0, 0, 0, 0, t);
        step(1, 1, 3, 0, 0, 0, 0, 0, 0, t);
        step(0, 0, 0, 0, 1, t + 5'd2, 32'hc2, 0, 0, t + 5'd2);
        step(0, 0, 0, 0, 1, t + 5'd1, 32'hc1, 0, 0, t + 5'd1);
        step(0, 0, 0, 0, 1, t, 32'hc0, 0, 0, t);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, t);
        for (int i = 0; i < 35; i++) step(1, 1, 5'($urandom), 0, 0, 0, 0, 0, 0, 5'($urandom));
        for (int i = 0; i < 8; i++) step(1, 1, 5'($urandom), 0, 1, rob[0].tag, $urandom, 0, 0, 5'($urandom));
        drain();
        t = m_tail;
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 10, 0, 1, t, 32'h55, 1, 32'h80, t);
        for (int i = 0; i < 4; i++) step(1, 1, 11, 0, 0, 0, 0, 0, 0, 0);
        drain();
        step(0, 0, 0, 0, 1, t + 5'd1, 32'h77, 0, 0, t + 5'd1);
        drain();
        for (int i = 0; i < 600; i++) rstep(85, 30);
        for (int i = 0; i < 900; i++) rstep(50, 60);
        drain();
        t = m_tail;
        step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 9, 0, 1, t, 32'habcd, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        run = 0;
        chk("pre_rst_write_en", write_en, 1);
        chk("pre_rst_count", count, 2);
        #2;
        rst = 0;
        #1;
        chk("async_write_en", write_en, 0);
        chk("async_count", count, 0);
        chk("async_write_id", write_id, 0);
        @(negedge clk);
        rst = 1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
